// File: rtl/mips_alu_branch_unit.sv
// Execute and next-PC stage of the single-cycle core: ALU, stored Z/N/V flags,
// branch/jump target generation and the program counter register.
module mips_alu_branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [2:0]  alu_op,
  input  logic        flag_we,
  input  logic [3:0]  jb_id,
  input  logic        jmadd,
  input  logic [31:0] imm_sext,
  input  logic [25:0] imm26,
  input  logic [31:0] ind_target,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        negative,
  output logic        overflow,
  output logic        z_q,
  output logic        n_q,
  output logic        v_q,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        link
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        slt;
  logic [31:0] bt;
  logic [31:0] jr;
  logic [31:0] ja;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  assign slt  = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_result = 32'h0;
    overflow   = 1'b0;
    case (alu_op)
      OP_AND: alu_result = op_a & op_b;
      OP_OR:  alu_result = op_a | op_b;
      OP_ADD: begin
        alu_result = sum;
        overflow   = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      OP_SUB: begin
        alu_result = diff;
        overflow   = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      OP_SLT: alu_result = {31'b0, slt};
      default: alu_result = 32'h0;
    endcase
  end

  assign zero     = (alu_result == 32'h0);
  assign negative = alu_result[31];

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign bt       = pc_plus4 + (imm_sext << 2);
  assign jr       = pc_plus4 + {4'b0, imm26, 2'b00};
  assign ja       = {pc_plus4[31:28], imm26, 2'b00};
  assign link     = jmadd | (~jb_id[3] & (jb_id[2:0] != 3'b000));

  // Conditional branches look only at the stored flags, never this cycle's ALU.
  always_comb begin
    pc_d = pc_plus4;
    if (jmadd) begin
      pc_d = ind_target;
    end else begin
      case (jb_id)
        4'b0001: pc_d = z_q ? bt : pc_plus4;
        4'b0010: pc_d = jr;
        4'b0011: pc_d = ja;
        4'b0100: pc_d = n_q ? bt : pc_plus4;
        4'b1000: pc_d = z_q ? bt : pc_plus4;
        4'b1001: pc_d = z_q ? pc_plus4 : bt;
        4'b1010: pc_d = ja;
        4'b1011: pc_d = n_q ? bt : pc_plus4;
        default: pc_d = pc_plus4;
      endcase
    end
  end

  assign next_pc = pc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 32'h0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (flag_we) begin
        z_q <= zero;
        n_q <= negative;
        v_q <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu_branch_unit.sv
// Directed and randomized bench for mips_alu_branch_unit, checked against an
// arithmetic reference model of the ALU, flags and next-PC rules.
module tb_mips_alu_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] op_a, op_b, imm_sext, ind_target;
  logic [2:0]  alu_op;
  logic        flag_we, jmadd;
  logic [3:0]  jb_id;
  logic [25:0] imm26;
  logic [31:0] alu_result, pc, pc_plus4, next_pc;
  logic        zero, negative, overflow, z_q, n_q, v_q, link;

  int checks = 0;
  int failures = 0;

  logic [31:0] mPc;
  logic        mZ, mN, mV;

  always #5 clk = ~clk;

  mips_alu_branch_unit dut (
    .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b), .alu_op(alu_op),
    .flag_we(flag_we), .jb_id(jb_id), .jmadd(jmadd), .imm_sext(imm_sext),
    .imm26(imm26), .ind_target(ind_target), .alu_result(alu_result),
    .zero(zero), .negative(negative), .overflow(overflow), .z_q(z_q),
    .n_q(n_q), .v_q(v_q), .pc(pc), .pc_plus4(pc_plus4), .next_pc(next_pc),
    .link(link)
  );

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd6: return a - b;
      3'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic refOvf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == 3'd2) s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 3'd6) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic [31:0] refNext(input logic [31:0] p, input logic z, input logic n);
    logic [31:0] p4, btgt, jrel, jabs;
    p4   = p + 32'd4;
    btgt = p4 + imm_sext * 32'd4;
    jrel = p4 + 32'(imm26) * 32'd4;
    jabs = (p4 & 32'hF000_0000) | (32'(imm26) * 32'd4);
    if (jmadd) return ind_target;
    case (jb_id)
      4'd1, 4'd8: return z ? btgt : p4;
      4'd9:       return z ? p4 : btgt;
      4'd4, 4'd11: return n ? btgt : p4;
      4'd2:       return jrel;
      4'd3, 4'd10: return jabs;
      default:    return p4;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic we, input logic [3:0] jb, input logic jm,
                               input logic [31:0] imm, input logic [25:0] i26, input logic [31:0] ind);
    op_a = a; op_b = b; alu_op = op; flag_we = we; jb_id = jb; jmadd = jm;
    imm_sext = imm; imm26 = i26; ind_target = ind;
    #2;
  endtask

  task automatic checkComb(input string tag);
    logic [31:0] r;
    r = refAlu(alu_op, op_a, op_b);
    checkOutput({tag, ".alu"}, alu_result, r);
    checkOutput({tag, ".zero"}, 32'(zero), 32'(r == 32'd0));
    checkOutput({tag, ".neg"}, 32'(negative), 32'(r[31]));
    checkOutput({tag, ".ovf"}, 32'(overflow), 32'(refOvf(alu_op, op_a, op_b)));
    checkOutput({tag, ".pc4"}, pc_plus4, mPc + 32'd4);
    checkOutput({tag, ".next"}, next_pc, refNext(mPc, mZ, mN));
    checkOutput({tag, ".link"}, 32'(link), 32'(jmadd || (jb_id >= 4'd1 && jb_id <= 4'd7)));
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".pc"}, pc, mPc);
    checkOutput({tag, ".zq"}, 32'(z_q), 32'(mZ));
    checkOutput({tag, ".nq"}, 32'(n_q), 32'(mN));
    checkOutput({tag, ".vq"}, 32'(v_q), 32'(mV));
  endtask

  // Checks this cycle's combinational view, clocks once, then checks the committed state.
  task automatic clockCycle(input string tag);
    logic [31:0] np, r;
    logic        o;
    checkComb(tag);
    np = refNext(mPc, mZ, mN);
    r  = refAlu(alu_op, op_a, op_b);
    o  = refOvf(alu_op, op_a, op_b);
    @(posedge clk);
    #1;
    mPc = np;
    if (flag_we) begin
      mZ = (r == 32'd0);
      mN = r[31];
      mV = o;
    end
    checkState(tag);
  endtask

  task automatic pulseReset(input string tag);
    rst_n = 1'b0;
    #1;
    mPc = 32'h0; mZ = 1'b0; mN = 1'b0; mV = 1'b0;
    checkState(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ra, rb, ri;
    logic        rjm;
    logic [15:0] r16;
    rst_n = 1'b0;
    applyStimulus(0, 0, 3'd0, 1'b0, 4'd0, 1'b0, 0, 26'd0, 0);
    mPc = 32'h0; mZ = 1'b0; mN = 1'b0; mV = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkState("reset");
    rst_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      clockCycle("seq");
      checkOutput("seqPc", pc, 32'(i * 4));
    end

    applyStimulus(32'h7FFF_FFFF, 32'h1, 3'd2, 1'b0, 4'd0, 1'b0, 0, 26'd0, 0);
    checkOutput("addRes", alu_result, 32'h8000_0000);
    checkOutput("addNeg", 32'(negative), 32'd1);
    checkOutput("addOvf", 32'(overflow), 32'd1);
    clockCycle("add");
    applyStimulus(32'd5, 32'd5, 3'd6, 1'b0, 4'd0, 1'b0, 0, 26'd0, 0);
    checkOutput("subZero", 32'(zero), 32'd1);
    clockCycle("sub");
    applyStimulus(32'hFFFF_FFFF, 32'd1, 3'd7, 1'b0, 4'd0, 1'b0, 0, 26'd0, 0);
    checkOutput("sltRes", alu_result, 32'd1);
    clockCycle("slt");
    applyStimulus(32'hF0F0, 32'hFF00, 3'd0, 1'b0, 4'd0, 1'b0, 0, 26'd0, 0);
    checkOutput("andRes", alu_result, 32'hF000);
    clockCycle("and");

    pulseReset("rst2");
    applyStimulus(0, 0, 3'd0, 1'b0, 4'd0, 1'b0, 0, 26'd0, 0);
    clockCycle("to4");
    applyStimulus(32'd3, 32'd3, 3'd6, 1'b1, 4'd0, 1'b0, 0, 26'd0, 0);
    clockCycle("sub33");
    applyStimulus(0, 0, 3'd0, 1'b0, 4'd8, 1'b0, 32'd2, 26'd0, 0);
    checkOutput("bzTaken", next_pc, 32'h14);
    clockCycle("bz1");
    applyStimulus(32'd3, 32'd2, 3'd6, 1'b1, 4'd0, 1'b0, 0, 26'd0, 0);
    clockCycle("sub32");
    applyStimulus(0, 0, 3'd0, 1'b0, 4'd8, 1'b0, 32'd2, 26'd0, 0);
    checkOutput("bzNotTaken", next_pc, 32'h1C);
    clockCycle("bz2");

    pulseReset("rst3");
    applyStimulus(0, 0, 3'd0, 1'b0, 4'd0, 1'b0, 0, 26'd0, 0);
    repeat (4) clockCycle("to10");
    applyStimulus(0, 0, 3'd0, 1'b0, 4'd10, 1'b0, 0, 26'd3, 0);
    checkOutput("jTarget", next_pc, 32'hC);
    checkOutput("jLink", 32'(link), 32'd0);
    applyStimulus(0, 0, 3'd0, 1'b0, 4'd2, 1'b0, 0, 26'd3, 0);
    checkOutput("jpcTarget", next_pc, 32'h20);
    checkOutput("jpcLink", 32'(link), 32'd1);
    applyStimulus(0, 0, 3'd0, 1'b0, 4'd0, 1'b1, 0, 26'd3, 32'h40);
    checkOutput("jmTarget", next_pc, 32'h40);
    checkOutput("jmLink", 32'(link), 32'd1);
    clockCycle("jm");

    applyStimulus(32'd7, 32'd7, 3'd6, 1'b1, 4'd9, 1'b0, 32'd4, 26'd0, 0);
    checkOutput("bnzOld", next_pc, 32'h54);
    clockCycle("bnz");
    checkOutput("bnzPc", pc, 32'h54);
    checkOutput("bnzZq", 32'(z_q), 32'd1);

    for (int i = 0; i < 300; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      r16 = 16'($urandom);
      ri  = {{16{r16[15]}}, r16};
      rjm = ($urandom_range(0, 9) == 0);
      applyStimulus(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    rjm ? 4'd0 : 4'($urandom_range(0, 15)), rjm, ri,
                    26'($urandom), $urandom);
      clockCycle("rand");
      if (i % 97 == 96) pulseReset("randRst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
